// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// digit geometry, FSM encodings and the shift-add-3 correction constants.
package bin2bcd_seq_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int ACC_W      = DIGIT_W * NUM_DIGITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit shift-add-3 correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  assign adj = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, with a start/busy/done
// handshake. Produces hundreds/tens/units digits after WIDTH shift cycles.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_next;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (acc[g*DIGIT_W +: DIGIT_W]),
      .adj   (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Correction happens on the pre-shift digits; the operand MSB enters units bit 0.
  assign acc_next = {acc_adj[ACC_W-2:0], sreg[WIDTH-1]};

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sreg  <= '0;
      acc   <= '0;
      done  <= 1'b0;
      bcd2  <= '0;
      bcd1  <= '0;
      bcd0  <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state <= ST_SHIFT;
          sreg  <= bin;
          acc   <= '0;
          cnt   <= CNT_W'(WIDTH);
        end
      end else begin
        acc  <= acc_next;
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state <= ST_IDLE;
          done  <= 1'b1;
          bcd2  <= acc_next[3*DIGIT_W-1 -: DIGIT_W];
          bcd1  <= acc_next[2*DIGIT_W-1 -: DIGIT_W];
          bcd0  <= acc_next[DIGIT_W-1   -: DIGIT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8).
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin = 8'd0;
  logic       busy;
  logic       done;
  logic [3:0] bcd2, bcd1, bcd0;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for done after the accepting edge; returns cycles counted (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
  endtask

  task automatic convert(input logic [7:0] v, input int e2, input int e1, input int e0,
                         input string tag);
    int n;
    @(negedge clk);
    bin = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_d2"}, bcd2, e2);
    chk({tag, "_d1"}, bcd1, e1);
    chk({tag, "_d0"}, bcd0, e0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n;
    int sum;
    int t1, u1;
    bit seen;
    logic [7:0] seq [4];

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", {bcd2, bcd1, bcd0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    convert(8'd0,   0, 0, 0, "zero");
    convert(8'd255, 2, 5, 5, "v255");
    convert(8'd99,  0, 9, 9, "v99");
    convert(8'd58,  0, 5, 8, "v58");
    t1 = bcd1; u1 = bcd0;
    convert(8'd53,  0, 5, 3, "v53");
    sum = (t1 * 10 + u1) + (bcd1 * 10 + bcd0);
    chk("adder_sum", sum, 111);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++)
      convert(8'(v), v / 100, (v / 10) % 10, v % 10, "sweep");

    // start re-asserted mid-conversion is ignored
    @(negedge clk);
    bin = 8'd77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; bin = 8'd33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = 8'd0;
    n = 3;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
    chk("ign_lat", n, 8);
    chk("ign_val", {bcd2, bcd1, bcd0}, 12'h077);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("ign_single_done", seen, 0);

    // Reset mid-conversion aborts
    @(negedge clk);
    bin = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bcd", {bcd2, bcd1, bcd0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    convert(8'd128, 1, 2, 8, "v128");

    // start held high: next conversion accepted in the done cycle
    seq[0] = 8'd10; seq[1] = 8'd20; seq[2] = 8'd30; seq[3] = 8'd0;
    @(negedge clk);
    bin = seq[0]; start = 1'b1;
    @(posedge clk); #1;
    bin = seq[1];
    for (int k = 0; k < 3; k++) begin
      wait_done(n);
      chk("b2b_lat", n, 8);
      chk("b2b_val", {bcd2, bcd1, bcd0}, (k + 1) << 4);
      chk("b2b_done_busy", busy, 0);
      if (k == 2) start = 1'b0;
      @(posedge clk); #1;
      if (k < 2) begin
        chk("b2b_reaccept", busy, 1);
        bin = seq[k + 2];
      end else begin
        chk("b2b_stop", busy, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
